// File: rtl/stream_upsizer_if.sv
// Stream bundle for the width up-converter.
//   s_*  : narrow input stream (data, last, valid in; ready out of the block)
//   m_*  : wide output stream (lanes, keep, last, valid out; ready into the block)
//   slave  : view taken by the up-converter itself
//   master : view taken by the producer/consumer side (testbench)
interface stream_upsizer_if #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
);
  logic [T_DATA_WIDTH-1:0] s_data_i;
  logic                    s_last_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] m_keep_o;
  logic                    m_last_o;
  logic                    m_valid_o;
  logic                    m_ready_i;

  modport slave (
    input  s_data_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/stream_upsizer.sv
// Width up-converter: packs up to T_DATA_RATIO narrow beats into one wide word
// with a per-lane keep mask; a packet end (s_last_i) flushes a partial word.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream_upsizer_if.slave (s_* narrow input, m_* wide output)

// One lane: accumulator slot plus its output register slot.
module stream_upsizer_lane #(
  parameter int T_DATA_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr,    // accepted beat targets this lane
  input  logic                    i_cmpl,  // accepted beat completes the word
  input  logic [T_DATA_WIDTH-1:0] i_data,
  output logic [T_DATA_WIDTH-1:0] o_data,
  output logic                    o_keep
);
  logic [T_DATA_WIDTH-1:0] r_acc;
  logic                    r_acc_keep;
  logic [T_DATA_WIDTH-1:0] r_out;
  logic                    r_out_keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_acc_keep <= 1'b0;
      r_out      <= '0;
      r_out_keep <= 1'b0;
    end else if (i_cmpl) begin
      // completing beat bypasses the accumulator straight into the output
      r_out      <= i_wr ? i_data : r_acc;
      r_out_keep <= i_wr | r_acc_keep;
      r_acc      <= '0;
      r_acc_keep <= 1'b0;
    end else if (i_wr) begin
      r_acc      <= i_data;
      r_acc_keep <= 1'b1;
    end
  end

  assign o_data = r_out;
  assign o_keep = r_out_keep;
endmodule

module stream_upsizer #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_upsizer_if.slave  bus
);
  localparam int CW = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;

  logic [CW-1:0]                            r_count;
  logic                                     r_m_valid;
  logic                                     r_m_last;
  logic                                     w_s_ready;
  logic                                     w_acc_beat;
  logic                                     w_cmpl;
  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] w_data;
  logic [T_DATA_RATIO-1:0]                  w_keep;

  // output register frees up either when empty or when draining this edge
  assign w_s_ready  = !r_m_valid || bus.m_ready_i;
  assign w_acc_beat = bus.s_valid_i && w_s_ready;
  assign w_cmpl     = w_acc_beat && ((r_count == CW'(T_DATA_RATIO-1)) || bus.s_last_i);

  genvar i;
  generate
    for (i = 0; i < T_DATA_RATIO; i++) begin : g_lane
      stream_upsizer_lane #(.T_DATA_WIDTH(T_DATA_WIDTH)) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_wr   (w_acc_beat && (r_count == CW'(i))),
        .i_cmpl (w_cmpl),
        .i_data (bus.s_data_i),
        .o_data (w_data[i]),
        .o_keep (w_keep[i])
      );
      assign bus.m_data_o[i] = w_data[i];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      if (w_acc_beat)
        r_count <= w_cmpl ? '0 : r_count + CW'(1);
      // a load on the drain edge keeps valid high
      if (w_cmpl) begin
        r_m_valid <= 1'b1;
        r_m_last  <= bus.s_last_i;
      end else if (bus.m_ready_i) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ready_o = w_s_ready;
  assign bus.m_keep_o  = w_keep;
  assign bus.m_last_o  = r_m_last;
  assign bus.m_valid_o = r_m_valid;
endmodule

// File: tb/tb_stream_upsizer.sv
module tb_stream_upsizer;
  localparam int W = 4;
  localparam int R = 2;

  typedef struct {
    logic [R-1:0][W-1:0] data;
    logic [R-1:0]        keep;
    logic                last;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_upsizer_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();
  stream_upsizer #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  word_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  logic  rnd_ready = 1'b0;
  logic  rdy_dir = 1'b1;
  logic  rdy_rand = 1'b1;
  logic  stop_rand = 1'b0;
  assign bus.m_ready_i = rnd_ready ? rdy_rand : rdy_dir;

  // reference model, used only for the random phase
  bit                  use_model = 1'b0;
  logic [R-1:0][W-1:0] m_acc = '0;
  logic [R-1:0]        m_keep = '0;
  int                  m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [R-1:0][W-1:0] d, input logic [R-1:0] k, input logic l);
    word_t w;
    w.data = d; w.keep = k; w.last = l;
    exp_q.push_back(w);
  endtask

  function automatic logic [R-1:0][W-1:0] out_data();
    logic [R-1:0][W-1:0] a;
    for (int i = 0; i < R; i++) a[i] = bus.m_data_o[i];
    return a;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // called at posedge+1; returns at posedge+1 after the beat transfers
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int t;
    bit ok;
    t = 0; ok = 1'b0;
    bus.s_data_i = d; bus.s_last_i = l; bus.s_valid_i = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (bus.s_ready_o) ok = 1'b1;
      else t++;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: beat %0h not accepted, required acceptance within 200 cycles", d);
    end else if (use_model) begin
      m_acc[m_cnt] = d;
      m_keep[m_cnt] = 1'b1;
      if (m_cnt == R-1 || l) begin
        expect_word(m_acc, m_keep, l);
        m_acc = '0; m_keep = '0; m_cnt = 0;
      end else m_cnt++;
    end
    @(posedge clk); #1;
    bus.s_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(posedge clk); #1; t++; end
    chk(name, exp_q.size(), 0);
  endtask

  // scoreboard monitor: a transfer happens on the next edge when valid&&ready at negedge
  task automatic monitor();
    word_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_valid_o && bus.m_ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_word: got data %0h keep %0b last %0b, required no word",
                   out_data(), bus.m_keep_o, bus.m_last_o);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 32'(out_data()), 32'(e.data));
          chk("word_keep", 32'(bus.m_keep_o), 32'(e.keep));
          chk("word_last", 32'(bus.m_last_o), 32'(e.last));
        end
      end
    end
  endtask

  task automatic rand_ready();
    while (!stop_rand) begin
      @(posedge clk); #1;
      rdy_rand = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    bus.s_last_i  = 1'b0;
    fork
      monitor();
      rand_ready();
    join_none

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.m_valid_o), 0);
    chk("rst_last", 32'(bus.m_last_o), 0);
    chk("rst_keep", 32'(bus.m_keep_o), 0);
    chk("rst_data", 32'(out_data()), 0);
    chk("rst_count", 32'(dut.r_count), 0);
    chk("rst_s_ready", 32'(bus.s_ready_o), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // 1: beat 0, gap, beat 2 last
    expect_word({4'h2, 4'h0}, 2'b11, 1'b1);
    send_beat(4'h0, 1'b0);
    idle(1);
    send_beat(4'h2, 1'b1);
    chk("t1_latency_valid", 32'(bus.m_valid_o), 1);
    chk("t1_count", 32'(dut.r_count), 0);
    wait_drain("t1_drained");

    // 2: back-to-back, then two single-beat packets
    expect_word({4'hB, 4'hA}, 2'b11, 1'b1);
    expect_word({4'h0, 4'h4}, 2'b01, 1'b1);
    expect_word({4'h0, 4'h0}, 2'b01, 1'b1);
    send_beat(4'hA, 1'b0);
    send_beat(4'hB, 1'b1);
    send_beat(4'h4, 1'b1);
    send_beat(4'h0, 1'b1);
    wait_drain("t2_drained");

    // 3: full word without last, then partial
    expect_word({4'hE, 4'h3}, 2'b11, 1'b0);
    expect_word({4'h0, 4'hB}, 2'b01, 1'b1);
    send_beat(4'h3, 1'b0);
    send_beat(4'hE, 1'b0);
    send_beat(4'hB, 1'b1);
    wait_drain("t3_drained");

    // 4: backpressure hold, then drain-and-load on one edge
    rdy_dir = 1'b0;
    expect_word({4'h6, 4'h5}, 2'b11, 1'b1);
    expect_word({4'h0, 4'h7}, 2'b01, 1'b1);
    send_beat(4'h5, 1'b0);
    send_beat(4'h6, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_s_ready", 32'(bus.s_ready_o), 0);
      chk("hold_valid", 32'(bus.m_valid_o), 1);
      chk("hold_data", 32'(out_data()), 32'h65);
      chk("hold_keep", 32'(bus.m_keep_o), 32'b11);
    end
    @(posedge clk); #1;
    rdy_dir = 1'b1;
    send_beat(4'h7, 1'b1);
    chk("t4_valid_after_swap", 32'(bus.m_valid_o), 1);
    wait_drain("t4_drained");
    idle(2);
    chk("t4_idle_valid", 32'(bus.m_valid_o), 0);

    // 5: reset mid-packet
    send_beat(4'h9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst5_valid", 32'(bus.m_valid_o), 0);
    chk("rst5_keep", 32'(bus.m_keep_o), 0);
    chk("rst5_count", 32'(dut.r_count), 0);
    chk("rst5_s_ready", 32'(bus.s_ready_o), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    expect_word({4'h0, 4'hC}, 2'b01, 1'b1);
    send_beat(4'hC, 1'b1);
    wait_drain("t5_drained");

    // 6: random beats, gaps and ready against the model
    use_model = 1'b1;
    rnd_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send_beat(W'($urandom), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    send_beat(4'h1, 1'b1);
    wait_drain("t6_drained");
    rnd_ready = 1'b0;
    stop_rand = 1'b1;
    idle(4);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
